// File: rtl/sha256_round_ctrl.sv
// SHA-256 block/round sequencer: accepts a message block, pulses the schedule load,
// steps 64 rounds, then updates the hash state. Optional block counter under SHA256_OPS_COUNT_EN.
module sha256_round_ctrl #(
    parameter int WORDSIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORDSIZE*16-1:0]  blk_data,
    input  logic                    blk_valid,
    input  logic                    blk_last,
    output logic                    blk_ready,
    output logic [WORDSIZE*16-1:0]  sched_M,
    output logic                    sched_load,
    output logic                    init_iv,
    output logic                    round_en,
    output logic [5:0]              round_idx,
    output logic                    hash_update,
    output logic                    digest_valid,
    input  logic                    dig_ready,
    output logic [31:0]             ops_count
);

    localparam int BW = WORDSIZE * 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUNDS,
        FINAL,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   sched_m_q, sched_m_d;
    logic            last_q, last_d;
    logic            first_q, first_d;
    logic [5:0]      idx_q, idx_d;
    logic            ready_q, ready_d;
    logic            load_q, load_d;
    logic            iv_q, iv_d;
    logic            ren_q, ren_d;
    logic            upd_q, upd_d;
    logic            dv_q, dv_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sched_m_q <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            idx_q     <= '0;
            ready_q   <= 1'b1;
            load_q    <= 1'b0;
            iv_q      <= 1'b0;
            ren_q     <= 1'b0;
            upd_q     <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sched_m_q <= sched_m_d;
            last_q    <= last_d;
            first_q   <= first_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            load_q    <= load_d;
            iv_q      <= iv_d;
            ren_q     <= ren_d;
            upd_q     <= upd_d;
            dv_q      <= dv_d;
        end
    end

    // Output flops are loaded from a decode of the next state so every output is a register.
    always_comb begin
        state_d   = state_q;
        sched_m_d = sched_m_q;
        last_d    = last_q;
        first_d   = first_q;
        idx_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (blk_valid && ready_q) begin
                    state_d   = LOAD;
                    sched_m_d = blk_data;
                    last_d    = blk_last;
                end
            end
            LOAD: begin
                state_d = ROUNDS;
                first_d = 1'b0;
            end
            ROUNDS: begin
                // Counter wraps 63->0 on the same edge that leaves ROUNDS.
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (dig_ready) begin
                    state_d = IDLE;
                    first_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        load_d  = (state_d == LOAD);
        iv_d    = (state_d == LOAD) && first_q;
        ren_d   = (state_d == ROUNDS);
        upd_d   = (state_d == FINAL);
        dv_d    = (state_d == DONE);
    end

    assign blk_ready    = ready_q;
    assign sched_M      = sched_m_q;
    assign sched_load   = load_q;
    assign init_iv      = iv_q;
    assign round_en     = ren_q;
    assign round_idx    = idx_q;
    assign hash_update  = upd_q;
    assign digest_valid = dv_q;

`ifdef SHA256_OPS_COUNT_EN
    logic [31:0] ops_q, ops_d;

    always_comb begin
        ops_d = ops_q;
        if (upd_q && (ops_q != '1)) begin
            ops_d = ops_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
        end else begin
            ops_q <= ops_d;
        end
    end

    assign ops_count = ops_q;
`else
    assign ops_count = '0;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed self-checking bench for sha256_round_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_sha256_round_ctrl;

    logic         clk;
    logic         rst;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;
    logic [511:0] sched_M;
    logic         sched_load;
    logic         init_iv;
    logic         round_en;
    logic [5:0]   round_idx;
    logic         hash_update;
    logic         digest_valid;
    logic         dig_ready;
    logic [31:0]  ops_count;

    int passed;
    int total;

    sha256_round_ctrl #(.WORDSIZE(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_data     (blk_data),
        .blk_valid    (blk_valid),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .sched_M      (sched_M),
        .sched_load   (sched_load),
        .init_iv      (init_iv),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .hash_update  (hash_update),
        .digest_valid (digest_valid),
        .dig_ready    (dig_ready),
        .ops_count    (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // One full block: accept, load, 64 rounds, final, then the post-final state.
    task automatic run_block(input logic [511:0] d, input logic last, input logic exp_iv,
                             input logic noise);
        int n;
        n = 0;
        while (blk_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (blk_ready !== 1'b1) $display("FAIL ready_wait: blk_ready=%b want 1", blk_ready);
        else passed++;

        blk_data  = d;
        blk_last  = last;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;

        total++;
        if ({sched_load, init_iv, round_en, hash_update, digest_valid, blk_ready} !==
            {1'b1, exp_iv, 4'b0000})
            $display("FAIL load_cycle: load/iv/ren/upd/dv/rdy=%b want %b",
                     {sched_load, init_iv, round_en, hash_update, digest_valid, blk_ready},
                     {1'b1, exp_iv, 4'b0000});
        else passed++;
        total++;
        if (sched_M !== d) $display("FAIL sched_M_capture: got %h want %h", sched_M, d);
        else passed++;

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            total++;
            if ({round_en, round_idx, sched_load, init_iv, hash_update, digest_valid, blk_ready} !==
                {1'b1, 6'(i), 5'b00000})
                $display("FAIL round_%0d: en=%b idx=%0d ld=%b iv=%b upd=%b dv=%b rdy=%b want en=1 idx=%0d others 0",
                         i, round_en, round_idx, sched_load, init_iv, hash_update, digest_valid,
                         blk_ready, i);
            else passed++;
            if (noise) begin
                blk_valid = (i < 63) ? ((i % 2) == 1) : 1'b0;
                blk_data  = {16{$urandom}};
                blk_last  = $urandom_range(0, 1);
            end
        end
        blk_valid = 1'b0;
        if (noise) begin
            total++;
            if (sched_M !== d) $display("FAIL sched_M_hold: got %h want %h", sched_M, d);
            else passed++;
        end

        @(negedge clk);
        total++;
        if ({hash_update, round_en, round_idx, sched_load, digest_valid, blk_ready} !==
            {1'b1, 1'b0, 6'd0, 3'b000})
            $display("FAIL final_cycle: upd=%b ren=%b idx=%0d ld=%b dv=%b rdy=%b want upd=1 others 0",
                     hash_update, round_en, round_idx, sched_load, digest_valid, blk_ready);
        else passed++;

        @(negedge clk);
        total++;
        if ({hash_update, round_en, sched_load, digest_valid, blk_ready} !==
            {3'b000, last, ~last})
            $display("FAIL after_final: upd=%b ren=%b ld=%b dv=%b rdy=%b want dv=%b rdy=%b",
                     hash_update, round_en, sched_load, digest_valid, blk_ready, last, ~last);
        else passed++;
    endtask

    task automatic release_digest();
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
        total++;
        if ({digest_valid, blk_ready} !== 2'b01)
            $display("FAIL release: dv=%b rdy=%b want dv=0 rdy=1", digest_valid, blk_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({sched_load, init_iv, round_en, round_idx, hash_update, digest_valid} !== 11'd0 ||
            sched_M !== '0 || ops_count !== 32'd0)
            $display("FAIL reset_state: ld=%b iv=%b ren=%b idx=%0d upd=%b dv=%b M=%h ops=%0d want all 0",
                     sched_load, init_iv, round_en, round_idx, hash_update, digest_valid,
                     sched_M, ops_count);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (blk_ready !== 1'b1) $display("FAIL reset_ready: blk_ready=%b want 1", blk_ready);
        else passed++;
    endtask

    task automatic test_abc();
        logic [511:0] b;
        b = '0;
        b[511:480] = 32'h61626380;
        b[31:0]    = 32'h00000018;
        run_block(b, 1'b1, 1'b1, 1'b0);
        release_digest();
    endtask

    task automatic test_two_block();
        run_block({16{32'h0123_4567}}, 1'b0, 1'b1, 1'b0);
        run_block({16{32'h89ab_cdef}}, 1'b1, 1'b0, 1'b0);
        release_digest();
    endtask

    task automatic test_dig_hold();
        run_block({16{32'h5555_aaaa}}, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            blk_valid = (i % 2) == 0;
            @(negedge clk);
            total++;
            if ({digest_valid, blk_ready, sched_load} !== 3'b100)
                $display("FAIL dig_hold_%0d: dv=%b rdy=%b ld=%b want dv=1 rdy=0 ld=0",
                         i, digest_valid, blk_ready, sched_load);
            else passed++;
        end
        blk_valid = 1'b0;
        release_digest();
        run_block({16{32'h0f0f_f0f0}}, 1'b1, 1'b1, 1'b0);
        release_digest();
    endtask

    task automatic test_ignore_inputs();
        run_block({16{32'hdead_beef}}, 1'b0, 1'b1, 1'b1);
        dig_ready = 1'b1;
        run_block({16{32'hcafe_f00d}}, 1'b1, 1'b0, 1'b0);
        dig_ready = 1'b0;
        release_digest();
    endtask

    task automatic test_rst_mid_rounds();
        int n;
        blk_data  = {16{32'h1357_9bdf}};
        blk_last  = 1'b1;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        n = 0;
        while (!(round_en === 1'b1 && round_idx === 6'd30) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (round_idx !== 6'd30) $display("FAIL rst_reach_r30: idx=%0d want 30", round_idx);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({sched_load, init_iv, round_en, round_idx, hash_update, digest_valid, blk_ready} !==
            {11'd0, 1'b1} || ops_count !== 32'd0)
            $display("FAIL rst_mid: ld=%b iv=%b ren=%b idx=%0d upd=%b dv=%b rdy=%b ops=%0d want rdy=1 rest 0",
                     sched_load, init_iv, round_en, round_idx, hash_update, digest_valid,
                     blk_ready, ops_count);
        else passed++;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (hash_update === 1'b1 || digest_valid === 1'b1 || round_en === 1'b1) n++;
        end
        total++;
        if (n != 0) $display("FAIL rst_abandon: %0d active cycles after reset want 0", n);
        else passed++;
    endtask

    task automatic test_ops_count();
        logic [31:0] exp_ops;
        run_block({16{32'h0000_0001}}, 1'b0, 1'b1, 1'b0);
        run_block({16{32'h0000_0002}}, 1'b0, 1'b0, 1'b0);
        run_block({16{32'h0000_0003}}, 1'b1, 1'b0, 1'b0);
`ifdef SHA256_OPS_COUNT_EN
        exp_ops = 32'd3;
`else
        exp_ops = 32'd0;
`endif
        total++;
        if (ops_count !== exp_ops) $display("FAIL ops_count: got %0d want %0d", ops_count, exp_ops);
        else passed++;
        release_digest();
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        blk_data  = '0;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        dig_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_two_block();
        test_dig_hold();
        test_ignore_inputs();
        test_rst_mid_rounds();
        test_ops_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
